// File: rtl/id_alloc_scheduler.sv
// Shares one ID allocate/restore unit between NUM_REQ requesters: round-robin
// allocation front end plus a buffered free path that takes priority.
module id_alloc_scheduler #(
  parameter int ID_WIDTH        = 4,
  parameter int NUM_REQ         = 2,
  parameter int FREE_FIFO_DEPTH = 4,
  parameter int REQ_IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_orig_id,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ID_WIDTH-1:0]          gnt_unique_id,
  output logic                         alloc_req,
  output logic [ID_WIDTH-1:0]          alloc_orig_id,
  input  logic                         alloc_gnt,
  input  logic [ID_WIDTH-1:0]          alloc_unique_id,
  input  logic                         alloc_full,
  input  logic                         free_valid,
  input  logic [ID_WIDTH-1:0]          free_unique_id,
  output logic                         free_ready,
  output logic                         free_req,
  output logic [ID_WIDTH-1:0]          free_id,
  input  logic [ID_WIDTH-1:0]          restored_id_in,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_orig_id,
  output logic [15:0]                  stall_cnt
);

  localparam int PTR_W = $clog2(FREE_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                 state_q;
  logic [REQ_IDX_W-1:0]   rr_ptr_q, win_idx_q, pick_idx, rr_next;
  logic [ID_WIDTH-1:0]    win_id_q;
  logic                   pick_vld, grant;

  logic [ID_WIDTH-1:0]    mem_q [FREE_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_q, rd_q;
  logic [PTR_W:0]         cnt_q;
  logic                   fifo_empty, push, pop;

  // Circular search from rr_ptr: walk offsets high to low so the smallest offset wins.
  always_comb begin
    logic [REQ_IDX_W:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_q} + (REQ_IDX_W + 1)'(i);
      if (sum >= (REQ_IDX_W + 1)'(NUM_REQ)) sum = sum - (REQ_IDX_W + 1)'(NUM_REQ);
      if (req_valid[sum[REQ_IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[REQ_IDX_W-1:0];
      end
    end
  end

  assign rr_next = (win_idx_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;

  assign fifo_empty    = (cnt_q == '0);
  assign free_ready    = ~rst & (cnt_q != (PTR_W + 1)'(FREE_FIFO_DEPTH));
  assign free_req      = ~fifo_empty;
  assign free_id       = free_req ? mem_q[rd_q] : '0;
  assign push          = free_valid & free_ready;
  assign pop           = free_req;

  // Queued frees lock out allocation so the allocator never sees both.
  assign alloc_req     = (state_q != IDLE) & fifo_empty & ~alloc_full;
  assign alloc_orig_id = alloc_req ? win_id_q : '0;
  assign grant         = alloc_req & alloc_gnt;
  assign gnt_unique_id = grant ? alloc_unique_id : '0;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      win_id_q  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state_q == WAIT && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      case (state_q)
        IDLE: if (pick_vld) begin
          win_idx_q <= pick_idx;
          win_id_q  <= req_orig_id[pick_idx*ID_WIDTH +: ID_WIDTH];
          state_q   <= REQ;
        end
        REQ, WAIT: if (grant) begin
          rr_ptr_q <= rr_next;
          state_q  <= IDLE;
        end else begin
          state_q  <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_orig_id <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      rsp_valid <= pop;
      if (pop) rsp_orig_id <= restored_id_in;
    end
  end

  // Storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= free_unique_id;
  end

endmodule

// File: tb/tb_id_alloc_scheduler.sv
// Random-stimulus bench for id_alloc_scheduler against a transaction-level model.
module tb_id_alloc_scheduler;

  localparam int IDW = 4, NR = 2, DEPTH = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*IDW-1:0] req_orig_id = '0;
  logic [NR-1:0]   req_ready;
  logic [IDW-1:0]  gnt_unique_id, alloc_orig_id, alloc_unique_id = '0;
  logic            alloc_req, alloc_gnt = 1'b0, alloc_full = 1'b0;
  logic            free_valid = 1'b0, free_ready, free_req, rsp_valid;
  logic [IDW-1:0]  free_unique_id = '0, free_id, restored_id_in, rsp_orig_id;
  logic [15:0]     stall_cnt;

  always #5 clk = ~clk;

  // Allocator's restore table stand-in: a fixed mapping of the freed ID.
  assign restored_id_in = free_id ^ 4'hA;

  id_alloc_scheduler #(.ID_WIDTH(IDW), .NUM_REQ(NR), .FREE_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_orig_id(req_orig_id), .req_ready(req_ready),
    .gnt_unique_id(gnt_unique_id),
    .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
    .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full),
    .free_valid(free_valid), .free_unique_id(free_unique_id), .free_ready(free_ready),
    .free_req(free_req), .free_id(free_id), .restored_id_in(restored_id_in),
    .rsp_valid(rsp_valid), .rsp_orig_id(rsp_orig_id), .stall_cnt(stall_cnt)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending request (phase 0 none, 1 fresh, 2 stalled), RR pointer, free queue.
  int             m_phase, m_win, m_rr, m_stall;
  logic [IDW-1:0] m_id, m_rsp_id;
  logic           m_rsp_v;
  logic [IDW-1:0] m_fifo[$];

  // Requester-side protocol state: a request is held until its ready pulse.
  logic [NR-1:0]  held = '0;
  logic [IDW-1:0] held_id [NR];

  int grants_per [NR];

  task automatic model_reset();
    m_phase = 0; m_win = 0; m_rr = 0; m_stall = 0;
    m_id = '0; m_rsp_id = '0; m_rsp_v = 1'b0;
    m_fifo.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(req_ready), 0);
    check({tag, "_gnt"},   32'(gnt_unique_id), 0);
    check({tag, "_areq"},  32'(alloc_req), 0);
    check({tag, "_aid"},   32'(alloc_orig_id), 0);
    check({tag, "_frdy"},  32'(free_ready), 0);
    check({tag, "_freq"},  32'(free_req), 0);
    check({tag, "_fid"},   32'(free_id), 0);
    check({tag, "_rspv"},  32'(rsp_valid), 0);
    check({tag, "_rspid"}, 32'(rsp_orig_id), 0);
    check({tag, "_stall"}, 32'(stall_cnt), 0);
  endtask

  // Per-segment stimulus biases (percent): request, grant, full, free.
  int p_req [5] = '{60, 90, 50, 80, 30};
  int p_gnt [5] = '{70, 90, 20, 60, 100};
  int p_full[5] = '{10,  0, 60, 20, 0};
  int p_frv [5] = '{20,  5, 30, 70, 90};

  initial begin
    logic           exp_areq, exp_freq, exp_frdy, grant;
    logic [NR-1:0]  exp_rdy;
    logic [IDW-1:0] exp_gnt, head;
    int             seg, p;
    bit             did_reset;

    model_reset();
    for (int k = 0; k < NR; k++) begin held_id[k] = '0; grants_per[k] = 0; end
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      seg = (cyc / 400) % 5;
      if (cyc != 0) @(negedge clk);

      for (int k = 0; k < NR; k++) begin
        if (!held[k] && $urandom_range(99) < p_req[seg]) begin
          held[k] = 1'b1;
          held_id[k] = IDW'($urandom);
        end
        req_valid[k] = held[k];
        req_orig_id[k*IDW +: IDW] = held_id[k];
      end
      alloc_gnt       = ($urandom_range(99) < p_gnt[seg]);
      alloc_full      = ($urandom_range(99) < p_full[seg]);
      alloc_unique_id = IDW'($urandom);
      free_valid      = ($urandom_range(99) < p_frv[seg]);
      free_unique_id  = IDW'($urandom);
      #1;

      exp_freq = (m_fifo.size() != 0);
      head     = exp_freq ? m_fifo[0] : '0;
      exp_frdy = (m_fifo.size() < DEPTH);
      exp_areq = (m_phase != 0) && !exp_freq && !alloc_full;
      grant    = exp_areq && alloc_gnt;
      exp_rdy  = grant ? NR'(1) << m_win : '0;
      exp_gnt  = grant ? alloc_unique_id : '0;

      check("alloc_req",     32'(alloc_req), 32'(exp_areq));
      check("alloc_orig_id", 32'(alloc_orig_id), 32'(exp_areq ? m_id : '0));
      check("req_ready",     32'(req_ready), 32'(exp_rdy));
      check("gnt_unique_id", 32'(gnt_unique_id), 32'(exp_gnt));
      check("free_req",      32'(free_req), 32'(exp_freq));
      check("free_id",       32'(free_id), 32'(head));
      check("free_ready",    32'(free_ready), 32'(exp_frdy));
      check("rsp_valid",     32'(rsp_valid), 32'(m_rsp_v));
      if (m_rsp_v) check("rsp_orig_id", 32'(rsp_orig_id), 32'(m_rsp_id));
      check("stall_cnt",     32'(stall_cnt), 32'(m_stall));
      check("exclusive",     32'(alloc_req & free_req), 0);

      // Occasionally yank reset asynchronously mid-cycle, favouring a stalled request.
      did_reset = 1'b0;
      if ((m_phase == 2 && $urandom_range(99) < 3) || cyc == 2000) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("arst");
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        did_reset = 1'b1;
      end

      if (!did_reset) begin
        m_rsp_v = exp_freq;
        if (exp_freq) begin
          m_rsp_id = head ^ 4'hA;
          void'(m_fifo.pop_front());
        end
        if (free_valid && exp_frdy) m_fifo.push_back(free_unique_id);
        if (m_phase == 2 && m_stall != 16'hFFFF) m_stall++;
        if (m_phase == 0) begin
          for (int o = NR - 1; o >= 0; o--) begin
            p = (m_rr + o) % NR;
            if (req_valid[p]) begin m_win = p; m_phase = 1; end
          end
          if (m_phase == 1) m_id = req_orig_id[m_win*IDW +: IDW];
        end else if (grant) begin
          m_rr = (m_win + 1) % NR;
          m_phase = 0;
          held[m_win] = 1'b0;
          grants_per[m_win]++;
        end else begin
          m_phase = 2;
        end
      end
    end

    for (int k = 0; k < NR; k++) check("any_grants", 32'(grants_per[k] > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
